// File: rtl/clock_tick_pkg.sv
// Shared definitions for the clock-enable scheduler: FSM encoding, channel roles
// and the standard periods used by the pixel, flicker and game-logic consumers.
package clock_tick_pkg;

  typedef enum logic [0:0] {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int CFG_CH_W = 3;

  localparam int CH_PIXEL   = 0;
  localparam int CH_FLICKER = 1;
  localparam int CH_GAME    = 2;
  localparam int CH_AUX     = 3;

  localparam int PERIOD_PIXEL   = 4;
  // Matches the legacy slow flicker divider's square-wave rate.
  localparam int PERIOD_FLICKER = 1 << 24;

  function automatic logic ch_in_range(input logic [CFG_CH_W-1:0] ch, input int num_ch);
    return int'(ch) < num_ch;
  endfunction

endpackage

// File: rtl/clock_tick_scheduler_channel.sv
// One tick channel: period counter producing a one-cycle enable and a square
// wave that toggles on every tick. Period reloads land only on a boundary.
module tick_channel
  import clock_tick_pkg::*;
#(
  parameter int CNT_W      = 27,
  parameter int DEF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             restart,
  input  logic             load,
  input  logic [CNT_W-1:0] load_period,
  output logic             tick,
  output logic             sq,
  output logic             wrap_next
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] period_reg;
  logic             tick_reg;
  logic             sq_reg;

  logic disabled;
  logic at_wrap;

  assign disabled = (period_reg == '0);
  assign at_wrap  = !disabled && (cnt_reg == period_reg - CNT_W'(1));

  // A stopped or disabled channel sits on a boundary, so a reload can land at once.
  assign wrap_next = !run || disabled || at_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      period_reg <= CNT_W'(DEF_PERIOD);
      tick_reg   <= 1'b0;
      sq_reg     <= 1'b0;
    end else if (restart) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
      sq_reg   <= 1'b0;
      if (load) period_reg <= load_period;
    end else if (!run) begin
      tick_reg <= 1'b0;
      if (load) begin
        period_reg <= load_period;
        cnt_reg    <= '0;
      end
    end else if (disabled) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
      sq_reg   <= 1'b0;
      if (load) period_reg <= load_period;
    end else if (at_wrap) begin
      // The boundary tick still belongs to the old period; the new one starts after it.
      cnt_reg  <= '0;
      tick_reg <= 1'b1;
      sq_reg   <= ~sq_reg;
      if (load) period_reg <= load_period;
    end else begin
      cnt_reg  <= cnt_reg + CNT_W'(1);
      tick_reg <= 1'b0;
    end
  end

  assign tick = tick_reg;
  assign sq   = sq_reg;

endmodule

// File: rtl/clock_tick_scheduler.sv
// Clock-enable scheduler top: run/stop FSM, single-entry config slot with a
// valid/ready handshake, and NUM_CH phase-aligned tick channels.
module clock_tick_scheduler
  import clock_tick_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 27,
  parameter int DEF_PERIOD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_en,
  input  logic                sync_restart,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_CH_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   sq,
  output logic                busy,
  output logic                running
);

  state_t state_reg;
  state_t state_next;

  logic                pending_reg;
  logic [CFG_CH_W-1:0] pend_ch_reg;
  logic [CNT_W-1:0]    pend_period_reg;

  logic              run;
  logic              cfg_accept;
  logic              apply;
  logic [NUM_CH-1:0] load_vec;
  logic [NUM_CH-1:0] wrap_next_vec;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_STOP;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_STOP: if (run_en)  state_next = ST_RUN;
      ST_RUN:  if (!run_en) state_next = ST_STOP;
      default: state_next = ST_STOP;
    endcase
  end

  always_comb begin
    running = 1'b0;
    if (state_reg == ST_RUN) running = 1'b1;
  end

  assign run        = (state_reg == ST_RUN);
  assign cfg_ready  = ~pending_reg;
  assign busy       = pending_reg;
  assign cfg_accept = cfg_valid && cfg_ready;
  assign apply      = |load_vec;

  // Requests for channels that do not exist complete the handshake but never occupy the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg     <= 1'b0;
      pend_ch_reg     <= '0;
      pend_period_reg <= '0;
    end else if (apply) begin
      pending_reg <= 1'b0;
    end else if (cfg_accept && ch_in_range(cfg_ch, NUM_CH)) begin
      pending_reg     <= 1'b1;
      pend_ch_reg     <= cfg_ch;
      pend_period_reg <= cfg_period;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign load_vec[gi] = pending_reg && (pend_ch_reg == CFG_CH_W'(gi))
                            && (sync_restart || wrap_next_vec[gi]);

      tick_channel #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD)
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .restart     (sync_restart),
        .load        (load_vec[gi]),
        .load_period (pend_period_reg),
        .tick        (tick[gi]),
        .sq          (sq[gi]),
        .wrap_next   (wrap_next_vec[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clock_tick_scheduler.sv
// Directed bench for clock_tick_scheduler: stimulus queues timestamped expectations,
// a negedge monitor compares each one against the DUT in its cycle.
module tb_clock_tick_scheduler;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 27;

  localparam int K_TICK  = 0;
  localparam int K_SQ    = 1;
  localparam int K_TICKB = 2;
  localparam int K_SQB   = 3;
  localparam int K_BUSY  = 4;
  localparam int K_READY = 5;
  localparam int K_RUN   = 6;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [3:0]  val;
    string       name;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              run_en;
  logic              sync_restart;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic              busy;
  logic              running;

  int   cyc = 0;
  int   t0 = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  clock_tick_scheduler #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEF_PERIOD (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run_en       (run_en),
    .sync_restart (sync_restart),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_period   (cfg_period),
    .tick         (tick),
    .sq           (sq),
    .busy         (busy),
    .running      (running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] actual(input int kind, input int idx);
    case (kind)
      K_TICK:  return tick;
      K_SQ:    return sq;
      K_TICKB: return {3'b000, tick[idx]};
      K_SQB:   return {3'b000, sq[idx]};
      K_BUSY:  return {3'b000, busy};
      K_READY: return {3'b000, cfg_ready};
      K_RUN:   return {3'b000, running};
      default: return 4'hx;
    endcase
  endfunction

  // Monitor: every expectation due this cycle is popped and compared.
  always @(negedge clk) begin
    exp_t keep[$];
    logic [3:0] got;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        got = actual(sb[i].kind, sb[i].idx);
        checks++;
        if (got !== sb[i].val) begin
          errors++;
          $display("FAIL %s cycle=%0d got=%h want=%h", sb[i].name, sb[i].cyc - t0, got, sb[i].val);
        end else begin
          $display("ok   %s cycle=%0d val=%h", sb[i].name, sb[i].cyc - t0, got);
        end
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s cycle=%0d got=missed want=%h", sb[i].name, sb[i].cyc - t0, sb[i].val);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic ex(input int k, input int kind, input int idx, input logic [3:0] val,
                    input string name);
    exp_t e;
    e.cyc  = t0 + k;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  // Moves to just after edge t0+k; inputs set here are sampled at the following edge.
  task automatic step_to(input int k);
    int guard;
    guard = 0;
    while (cyc < t0 + k && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != t0 + k) begin
      checks++;
      errors++;
      $display("FAIL step_to got=%0d want=%0d", cyc - t0, k);
    end
  endtask

  task automatic cfg_req(input int ch, input int period);
    cfg_valid  = 1'b1;
    cfg_ch     = 3'(ch);
    cfg_period = CNT_W'(period);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    run_en       = 1'b1;
    sync_restart = 1'b0;
    cfg_valid    = 1'b0;
    cfg_ch       = '0;
    cfg_period   = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    t0 = cyc;

    // Reset state, then default P=4 with run_en high.
    ex(0, K_TICK, 0, 4'h0, "rst_tick");
    ex(0, K_SQ, 0, 4'h0, "rst_sq");
    ex(0, K_BUSY, 0, 4'h0, "rst_busy");
    ex(0, K_READY, 0, 4'h1, "rst_ready");
    ex(0, K_RUN, 0, 4'h0, "rst_running");
    ex(1, K_RUN, 0, 4'h1, "run_enter");
    ex(4, K_TICK, 0, 4'h0, "pre_first_tick");
    ex(5, K_TICK, 0, 4'hF, "first_tick");
    ex(5, K_SQ, 0, 4'hF, "first_sq");
    ex(5, K_READY, 0, 4'h1, "idle_ready");
    ex(6, K_TICK, 0, 4'h0, "tick_one_cycle");
    ex(9, K_TICK, 0, 4'hF, "second_tick");
    ex(9, K_SQ, 0, 4'h0, "second_sq");
    rst = 1'b0;

    // ch1 -> P=7 while cnt1=1; applied at its old-period wrap.
    step_to(10);
    cfg_req(1, 7);
    ex(11, K_BUSY, 0, 4'h1, "ch1_busy");
    ex(11, K_READY, 0, 4'h0, "ch1_notready");
    ex(12, K_BUSY, 0, 4'h1, "ch1_busy_hold");
    ex(13, K_TICK, 0, 4'hF, "ch1_old_boundary");
    ex(13, K_BUSY, 0, 4'h0, "ch1_applied");
    ex(13, K_READY, 0, 4'h1, "ch1_ready_back");
    ex(17, K_TICK, 0, 4'b1101, "ch1_skip17");
    ex(20, K_TICK, 0, 4'b0010, "ch1_p7_tick20");
    ex(20, K_SQB, 1, 4'h0, "ch1_sq20");
    ex(21, K_TICK, 0, 4'b1101, "others_tick21");
    ex(27, K_TICKB, 1, 4'h1, "ch1_p7_tick27");
    ex(27, K_SQB, 1, 4'h1, "ch1_sq27");
    step_to(11);
    cfg_valid = 1'b0;

    // ch2 -> P=0: final tick at wrap, then silent with sq low.
    step_to(18);
    cfg_req(2, 0);
    ex(19, K_BUSY, 0, 4'h1, "ch2_off_busy");
    ex(21, K_BUSY, 0, 4'h0, "ch2_off_applied");
    ex(23, K_TICKB, 2, 4'h0, "ch2_off_tick");
    ex(23, K_SQB, 2, 4'h0, "ch2_off_sq");
    ex(25, K_TICK, 0, 4'b1001, "ch2_off_tick25");
    ex(25, K_SQB, 2, 4'h0, "ch2_off_sq25");
    ex(29, K_TICKB, 2, 4'h0, "ch2_off_tick29");
    step_to(19);
    cfg_valid = 1'b0;

    // ch2 -> P=3 from disabled: applied on the next edge.
    step_to(30);
    cfg_req(2, 3);
    ex(31, K_BUSY, 0, 4'h1, "ch2_p3_busy");
    ex(32, K_BUSY, 0, 4'h0, "ch2_p3_applied");
    ex(33, K_TICKB, 2, 4'h0, "ch2_p3_tick33");
    ex(35, K_TICK, 0, 4'b0100, "ch2_p3_tick35");
    ex(35, K_SQB, 2, 4'h1, "ch2_p3_sq35");
    ex(36, K_TICKB, 2, 4'h0, "ch2_p3_tick36");
    ex(38, K_TICKB, 2, 4'h1, "ch2_p3_tick38");
    ex(38, K_SQB, 2, 4'h0, "ch2_p3_sq38");
    step_to(31);
    cfg_valid = 1'b0;

    // Stop for 10 edges with cnt0=2; resume needs exactly 2 RUN edges.
    step_to(38);
    run_en = 1'b0;
    ex(39, K_RUN, 0, 4'h0, "stop_enter");
    ex(40, K_TICK, 0, 4'h0, "stop_tick40");
    ex(45, K_TICK, 0, 4'h0, "stop_tick45");
    ex(45, K_SQ, 0, 4'b1001, "stop_sq_hold");
    ex(49, K_RUN, 0, 4'h1, "resume_run");
    ex(50, K_TICK, 0, 4'h0, "resume_tick50");
    ex(51, K_TICK, 0, 4'hF, "resume_tick51");
    ex(51, K_SQ, 0, 4'b0110, "resume_sq51");
    step_to(48);
    run_en = 1'b1;

    // sync_restart with pending ch3 P=5.
    step_to(52);
    cfg_req(3, 5);
    ex(53, K_BUSY, 0, 4'h1, "ch3_busy");
    ex(53, K_READY, 0, 4'h0, "ch3_notready");
    ex(54, K_TICK, 0, 4'h0, "restart_tick");
    ex(54, K_SQ, 0, 4'h0, "restart_sq");
    ex(54, K_BUSY, 0, 4'h0, "restart_applied");
    ex(57, K_TICK, 0, 4'b0100, "restart_tick57");
    ex(58, K_TICK, 0, 4'b0001, "restart_tick58");
    ex(58, K_SQ, 0, 4'b0101, "restart_sq58");
    ex(59, K_TICK, 0, 4'b1000, "ch3_p5_tick59");
    ex(59, K_SQ, 0, 4'b1101, "restart_sq59");
    ex(60, K_TICK, 0, 4'b0100, "restart_tick60");
    ex(61, K_TICK, 0, 4'b0010, "restart_tick61");
    ex(64, K_TICK, 0, 4'b1000, "ch3_p5_tick64");
    step_to(53);
    cfg_valid    = 1'b0;
    sync_restart = 1'b1;
    step_to(54);
    sync_restart = 1'b0;

    // Out-of-range channel is accepted and dropped.
    step_to(65);
    cfg_req(6, 9);
    ex(66, K_BUSY, 0, 4'h0, "badch_busy");
    ex(66, K_READY, 0, 4'h1, "badch_ready");
    ex(66, K_TICK, 0, 4'b0101, "badch_tick66");
    ex(69, K_TICK, 0, 4'b1100, "badch_tick69");
    ex(70, K_TICK, 0, 4'b0001, "badch_tick70");
    step_to(66);
    cfg_valid = 1'b0;

    // Reset mid-operation with a config pending.
    step_to(70);
    cfg_req(1, 9);
    ex(71, K_BUSY, 0, 4'h1, "prerst_busy");
    ex(71, K_SQ, 0, 4'b1100, "prerst_sq");
    ex(72, K_TICK, 0, 4'h0, "rst2_tick");
    ex(72, K_SQ, 0, 4'h0, "rst2_sq");
    ex(72, K_BUSY, 0, 4'h0, "rst2_busy");
    ex(72, K_READY, 0, 4'h1, "rst2_ready");
    ex(72, K_RUN, 0, 4'h0, "rst2_running");
    ex(73, K_RUN, 0, 4'h1, "rst2_run_enter");
    ex(76, K_TICK, 0, 4'h0, "rst2_pre_tick");
    ex(77, K_TICK, 0, 4'hF, "rst2_first_tick");
    step_to(71);
    cfg_valid = 1'b0;
    rst       = 1'b1;
    step_to(72);
    rst = 1'b0;

    // P=1 on ch0: tick held high, sq toggles every cycle.
    step_to(78);
    cfg_req(0, 1);
    ex(79, K_BUSY, 0, 4'h1, "p1_busy79");
    ex(80, K_BUSY, 0, 4'h1, "p1_busy80");
    ex(81, K_TICK, 0, 4'hF, "p1_old_boundary");
    ex(81, K_BUSY, 0, 4'h0, "p1_applied");
    ex(82, K_TICK, 0, 4'b0001, "p1_tick82");
    ex(83, K_TICKB, 0, 4'h1, "p1_tick83");
    ex(83, K_SQB, 0, 4'h0, "p1_sq83");
    ex(84, K_TICKB, 0, 4'h1, "p1_tick84");
    ex(84, K_SQB, 0, 4'h1, "p1_sq84");
    step_to(79);
    cfg_valid = 1'b0;

    step_to(86);
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s cycle=%0d got=unchecked want=%h", sb[i].name, sb[i].cyc - t0, sb[i].val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_tick_scheduler.md
Name: clock_tick_scheduler

Overview:
Central clock-enable generator and scheduler. Replaces free-running divided clocks with single-cycle tick enables and matching square-wave outputs, one per channel, all in the `clk` domain. Pixel, flicker and game-logic consumers share it. Periods are reprogrammable at runtime through a valid/ready config port and take effect glitch-free at the next channel boundary. A global run/stop FSM and a sync-restart control keep all channels phase-aligned.

Parameters:
NUM_CH, 4, number of tick channels (1..8)
CNT_W, 27, counter/period width in bits
DEF_PERIOD, 4, period loaded into every channel at reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
run_en  input  1  1 = channels count; 0 = channels hold state
sync_restart  input  1  one-cycle pulse; clears all counters and square outputs
cfg_valid  input  1  config request valid
cfg_ready  output  1  config slot free; transfer occurs when cfg_valid && cfg_ready at posedge
cfg_ch  input  3  target channel index
cfg_period  input  CNT_W  new period in clk cycles; 0 = channel disabled
tick  output  NUM_CH  registered one-cycle enable per channel
sq  output  NUM_CH  registered square wave per channel; toggles on each tick
busy  output  1  config pending, not yet applied
running  output  1  FSM in RUN

Behaviour:
- Reset is synchronous, only on posedge clk with rst=1.
  - Per channel: cnt=0, period=DEF_PERIOD.
  - tick=0, sq=0, pending slot empty, cfg_ready=1, busy=0, state=STOP, running=0.
- FSM states and transitions:
  - STOP→RUN on an edge with run_en=1.
  - RUN→STOP on an edge with run_en=0.
  - running=1 exactly while in RUN.
  - In STOP, cnt, sq and period hold and tick=0.
- Counting, in RUN, per channel with period P≥1:
  - At an edge with cnt==P-1: cnt←0, tick←1, sq←~sq.
  - Otherwise: cnt←cnt+1, tick←0.
  - Result: ticks spaced exactly P cycles.
  - Latency: first tick is high during the cycle after the P-th RUN edge following restart or reset.
- P=1: tick held high continuously; sq toggles every cycle.
- P=0: channel disabled; cnt held 0, tick=0, sq←0.
- Width rule: cnt compares against P-1 in CNT_W bits. No overflow is possible because cnt never exceeds P-1.
- Config handshake:
  - cfg_ready = ~pending.
  - On accept, {cfg_ch, cfg_period} is latched into the pending slot and busy←1.
  - cfg_ch ≥ NUM_CH is accepted and silently dropped; the slot stays empty and busy stays 0.
  - No new accept occurs while busy.
- Applying a pending config:
  - In STOP, or if the target channel's current P is 0: apply on the next edge. period←new, cnt←0, sq unchanged.
  - In RUN with target P≥1: apply at the target's wrap edge. That edge emits its tick with the old period, then loads the new period with cnt←0.
  - Pending clears on the apply edge; cfg_ready returns high the next cycle.
  - New period 0 applied at wrap: the final tick is still emitted, then the channel is disabled and sq←0.
- sync_restart: all cnt←0, sq←0, tick←0. Any pending config is applied on that same edge. FSM state is unchanged.
- Priority per edge: rst > sync_restart > config apply > normal count.
- run_en falling in the same cycle a wrap is due: the edge still evaluates as RUN, so the tick is emitted and the FSM then enters STOP.
- tick and sq come directly from flops, with no combinational path from inputs.

Decomposition:
- Shared package clock_tick_pkg holds:
  - FSM encodings ST_STOP=1'b0, ST_RUN=1'b1.
  - Channel index constants CH_PIXEL=0, CH_FLICKER=1, CH_GAME=2, CH_AUX=3.
  - Standard periods PERIOD_PIXEL=4 and PERIOD_FLICKER=2^24 (sq matches the legacy slow flicker rate).
- One sub-module, tick_channel, instantiated NUM_CH times.
  - Contains cnt, period, tick and sq flops.
  - Inputs: run, restart, load, load_period.
  - Output: wrap_next, used by the top for apply timing.
- The top holds the FSM, the pending slot and the handshake.

Test Plan:
- Reset, then run_en=1 at default P=4: every tick[i] first high in cycle 5 after reset release, then every 4 cycles; sq toggles per tick; cfg_ready=1.
- In RUN, write ch1 period=7 while cnt1=1: busy=1 and cfg_ready=0 until ch1 wraps at old P=4; one tick at the old boundary, then spacing 7; other channels undisturbed.
- Write ch2 period=0 in RUN: final tick at the next wrap, then tick2=0 and sq2=0 permanently. Write ch2 period=3: applied next cycle; ticks every 3.
- run_en low for 10 cycles mid-count with cnt0=2, P=4: no ticks, sq held; after run_en high, the next tick comes after exactly 2 RUN edges.
- sync_restart with a pending ch3 period=5 and different channel phases: all cnt=0, sq=0; ch3 uses P=5 immediately; all channels with equal period tick in the same cycle thereafter.
- cfg_ch=6 accepted: no channel changes; busy stays 0. Assert rst mid-operation: all outputs return to reset values on that edge.
